// File: rtl/spi_router_pkg.sv
// Shared definitions for the SPI minion router: packet field layout,
// field extraction helpers and the push opcode decode.
package spi_router_pkg;

  // Widest packet the helpers accept; callers zero-extend into this width.
  localparam int MAX_NBITS = 64;
  localparam int DATA_LSB  = 0;

  typedef enum logic [1:0] {NOP, WRITE, READ, CLEAR} op_e;

  // Packet layout, MSB first: {wrt, rd, addr[abits], data[nbits-2-abits]}
  function automatic int wrt_pos(input int nbits);
    return nbits - 1;
  endfunction

  function automatic int rd_pos(input int nbits);
    return nbits - 2;
  endfunction

  function automatic int addr_lsb(input int nbits, input int abits);
    return nbits - 2 - abits;
  endfunction

  function automatic logic [MAX_NBITS-1:0] field_mask(input int w);
    return {MAX_NBITS{1'b1}} >> (MAX_NBITS - w);
  endfunction

  function automatic logic pkt_wrt(input logic [MAX_NBITS-1:0] pkt, input int nbits);
    logic [MAX_NBITS-1:0] s;
    s = pkt >> wrt_pos(nbits);
    return s[0];
  endfunction

  function automatic logic pkt_rd(input logic [MAX_NBITS-1:0] pkt, input int nbits);
    logic [MAX_NBITS-1:0] s;
    s = pkt >> rd_pos(nbits);
    return s[0];
  endfunction

  function automatic logic [MAX_NBITS-1:0] pkt_addr(input logic [MAX_NBITS-1:0] pkt,
                                                    input int nbits, input int abits);
    return (pkt >> addr_lsb(nbits, abits)) & field_mask(abits);
  endfunction

  function automatic logic [MAX_NBITS-1:0] pkt_data(input logic [MAX_NBITS-1:0] pkt,
                                                    input int dbits);
    return (pkt >> DATA_LSB) & field_mask(dbits);
  endfunction

  function automatic op_e decode_op(input logic wrt, input logic rd);
    case ({wrt, rd})
      2'b10:   return WRITE;
      2'b01:   return READ;
      2'b11:   return CLEAR;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/spi_router_fifo.sv
// Small synchronous FIFO with registered storage and no bypass; accepts an
// enqueue while full only when an entry leaves in the same cycle.
module spi_router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int MEMD = 2 ** PW;

  logic [WIDTH-1:0] mem [MEMD];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_enq, do_deq;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_deq = deq && !empty;
  assign do_enq = enq && (!full || do_deq);
  assign head   = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= bump(wr_ptr);
      if (do_deq) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_enq) - CW'(do_deq);
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/spi_minion_router.sv
// Routes SPI minion packets to per-channel master-to-chip queues and
// returns chip-to-master data through a selector-addressed pull path.
module spi_minion_router
  import spi_router_pkg::*;
#(
  parameter int NBITS = 12,
  parameter int NCH   = 4,
  parameter int DEPTH = 2,
  localparam int ABITS = $clog2(NCH),
  localparam int DBITS = NBITS - 2 - ABITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_en,
  input  logic [NBITS-1:0]     push_msg,
  input  logic                 pull_en,
  output logic [NBITS-1:0]     pull_msg,
  output logic [NCH-1:0]       send_val,
  input  logic [NCH-1:0]       send_rdy,
  output logic [NCH*DBITS-1:0] send_msg,
  input  logic [NCH-1:0]       recv_val,
  output logic [NCH-1:0]       recv_rdy,
  input  logic [NCH*DBITS-1:0] recv_msg,
  output logic [NCH-1:0]       overflow
);

  if (DBITS < 1) begin : g_bad_width
    $error("spi_minion_router: NBITS too small for NCH, no data bits remain");
  end
  if (NBITS > MAX_NBITS) begin : g_too_wide
    $error("spi_minion_router: NBITS exceeds package MAX_NBITS");
  end

  logic [MAX_NBITS-1:0] pkt;
  logic                 cmd_wrt, cmd_rd;
  logic [ABITS-1:0]     cmd_addr;
  logic [DBITS-1:0]     cmd_data;
  op_e                  cmd_op;

  assign pkt      = MAX_NBITS'(push_msg);
  assign cmd_wrt  = pkt_wrt(pkt, NBITS);
  assign cmd_rd   = pkt_rd(pkt, NBITS);
  assign cmd_addr = ABITS'(pkt_addr(pkt, NBITS, ABITS));
  assign cmd_data = DBITS'(pkt_data(pkt, DBITS));
  assign cmd_op   = decode_op(cmd_wrt, cmd_rd);

  logic [ABITS-1:0] sel;
  logic [NCH-1:0]   mc_full, mc_empty, mc_enq, mc_deq;
  logic [NCH-1:0]   cm_full, cm_empty, cm_enq, cm_deq;
  logic [NCH-1:0]   drop, clr;
  logic [DBITS-1:0] mc_head [NCH];
  logic [DBITS-1:0] cm_head [NCH];

  always_ff @(posedge clk) begin
    if (reset)        sel <= '0;
    else if (push_en) sel <= cmd_addr;
  end

  // A clear on the same channel as a drop wins: the clear mask is applied last.
  always_ff @(posedge clk) begin
    if (reset) overflow <= '0;
    else       overflow <= (overflow | drop) & ~clr;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit = (cmd_addr == ABITS'(i));

    assign mc_enq[i] = push_en && (cmd_op == WRITE) && hit && !mc_full[i];
    assign drop[i]   = push_en && (cmd_op == WRITE) && hit &&  mc_full[i];
    assign clr[i]    = push_en && (cmd_op == CLEAR) && hit;
    assign mc_deq[i] = !mc_empty[i] && send_rdy[i];

    // CM stays ready while full if the pull path frees an entry this cycle.
    assign cm_deq[i]   = pull_en && (cmd_op == READ) && !cm_empty[i] && (sel == ABITS'(i));
    assign recv_rdy[i] = !cm_full[i] || cm_deq[i];
    assign cm_enq[i]   = recv_val[i] && recv_rdy[i];

    assign send_val[i]                 = !mc_empty[i];
    assign send_msg[i*DBITS +: DBITS]  = mc_empty[i] ? '0 : mc_head[i];

    spi_router_fifo #(.WIDTH(DBITS), .DEPTH(DEPTH)) u_mc (
      .clk      (clk),
      .reset    (reset),
      .enq      (mc_enq[i]),
      .enq_data (cmd_data),
      .deq      (mc_deq[i]),
      .head     (mc_head[i]),
      .full     (mc_full[i]),
      .empty    (mc_empty[i])
    );

    spi_router_fifo #(.WIDTH(DBITS), .DEPTH(DEPTH)) u_cm (
      .clk      (clk),
      .reset    (reset),
      .enq      (cm_enq[i]),
      .enq_data (recv_msg[i*DBITS +: DBITS]),
      .deq      (cm_deq[i]),
      .head     (cm_head[i]),
      .full     (cm_full[i]),
      .empty    (cm_empty[i])
    );
  end

  logic             pull_val, pull_spc;
  logic [DBITS-1:0] pull_data;

  assign pull_val  = !cm_empty[sel];
  assign pull_spc  = !mc_full[sel];
  assign pull_data = pull_val ? cm_head[sel] : '0;
  assign pull_msg  = {pull_val, pull_spc, sel, pull_data};

endmodule

// File: tb/tb_spi_minion_router.sv
// Scoreboard bench for spi_minion_router: a DEPTH=2 instance for the main
// scenarios and a DEPTH=1 instance for single-entry queue behaviour.
module tb_spi_minion_router;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic        push_en, pull_en;
  logic [11:0] push_msg, pull_msg;
  logic [3:0]  send_val, send_rdy, recv_val, recv_rdy, overflow;
  logic [31:0] send_msg, recv_msg;

  // DEPTH=1 instance
  logic        b_push_en, b_pull_en;
  logic [11:0] b_push_msg, b_pull_msg;
  logic [3:0]  b_send_val, b_send_rdy, b_recv_val, b_recv_rdy, b_overflow;
  logic [31:0] b_send_msg, b_recv_msg;

  spi_minion_router #(.NBITS(12), .NCH(4), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .push_en(push_en), .push_msg(push_msg),
    .pull_en(pull_en), .pull_msg(pull_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .overflow(overflow)
  );

  spi_minion_router #(.NBITS(12), .NCH(4), .DEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .push_en(b_push_en), .push_msg(b_push_msg),
    .pull_en(b_pull_en), .pull_msg(b_pull_msg),
    .send_val(b_send_val), .send_rdy(b_send_rdy), .send_msg(b_send_msg),
    .recv_val(b_recv_val), .recv_rdy(b_recv_rdy), .recv_msg(b_recv_msg),
    .overflow(b_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected data per channel, oldest first.
  logic [7:0] mc_q [4][$];
  logic [7:0] cm_q [4][$];
  logic [3:0] exp_ovf;

  function automatic logic [11:0] mk(input logic w, input logic r,
                                     input logic [1:0] a, input logic [7:0] d);
    return {w, r, a, d};
  endfunction

  function automatic logic [11:0] pm(input logic v, input logic s,
                                     input logic [1:0] a, input logic [7:0] d);
    return {v, s, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    push_en = 1'b0; pull_en = 1'b0; push_msg = '0;
    send_rdy = '0; recv_val = '0; recv_msg = '0;
    b_push_en = 1'b0; b_pull_en = 1'b0; b_push_msg = '0;
    b_send_rdy = '0; b_recv_val = '0; b_recv_msg = '0;
  endtask

  // Issue one write to the DEPTH=2 instance and update the model.
  task automatic write_a(input logic [1:0] ch, input logic [7:0] d);
    push_en = 1'b1;
    push_msg = mk(1'b1, 1'b0, ch, d);
    if (mc_q[ch].size() < 2) mc_q[ch].push_back(d);
    else exp_ovf[ch] = 1'b1;
    tick();
    push_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    exp_ovf = '0;
    #1;
    n_checks++;
    if (send_val !== 4'h0) $display("FAIL reset_send_val: got %h want 0", send_val);
    else n_pass++;
    n_checks++;
    if (recv_rdy !== 4'hF) $display("FAIL reset_recv_rdy: got %h want f", recv_rdy);
    else n_pass++;
    n_checks++;
    if (overflow !== 4'h0) $display("FAIL reset_overflow: got %h want 0", overflow);
    else n_pass++;
    n_checks++;
    if (pull_msg !== pm(1'b0, 1'b1, 2'd0, 8'h00))
      $display("FAIL reset_pull_msg: got %h want %h", pull_msg, pm(1'b0, 1'b1, 2'd0, 8'h00));
    else n_pass++;
    n_checks++;
    if (b_pull_msg !== 12'h400 || b_recv_rdy !== 4'hF || b_send_val !== 4'h0)
      $display("FAIL reset_depth1: got pull=%h rdy=%h val=%h want 400 f 0",
               b_pull_msg, b_recv_rdy, b_send_val);
    else n_pass++;
  endtask

  task automatic test_overflow();
    send_rdy = '0;
    write_a(2'd2, 8'h2A);
    write_a(2'd2, 8'h15);
    write_a(2'd2, 8'h33);
    #1;
    n_checks++;
    if (overflow !== exp_ovf) $display("FAIL ovf_set: got %b want %b", overflow, exp_ovf);
    else n_pass++;
    n_checks++;
    if (send_val !== 4'b0100) $display("FAIL ovf_send_val: got %b want 0100", send_val);
    else n_pass++;
    n_checks++;
    if (pull_msg !== pm(1'b0, 1'b0, 2'd2, 8'h00))
      $display("FAIL ovf_no_space: got %h want %h", pull_msg, pm(1'b0, 1'b0, 2'd2, 8'h00));
    else n_pass++;
    n_checks++;
    if ({send_msg[31:24], send_msg[15:0]} !== 24'h0 || recv_rdy !== 4'hF)
      $display("FAIL ovf_other_ch: got msg=%h rdy=%h want 000000 f",
               {send_msg[31:24], send_msg[15:0]}, recv_rdy);
    else n_pass++;
    send_rdy[2] = 1'b1;
    for (int k = 0; k < 4 && send_val[2]; k++) begin
      #1;
      n_checks++;
      if (mc_q[2].size() == 0)
        $display("FAIL ovf_drain_extra: got %h want nothing", send_msg[23:16]);
      else if (send_msg[23:16] !== mc_q[2][0])
        $display("FAIL ovf_drain: got %h want %h", send_msg[23:16], mc_q[2][0]);
      else n_pass++;
      if (mc_q[2].size() != 0) void'(mc_q[2].pop_front());
      tick();
    end
    send_rdy = '0;
    #1;
    n_checks++;
    if (send_val !== 4'h0 || mc_q[2].size() != 0)
      $display("FAIL ovf_drained: got val=%h left=%0d want 0 0", send_val, mc_q[2].size());
    else n_pass++;
  endtask

  task automatic test_read();
    recv_val[1] = 1'b1;
    recv_msg = 32'h0000_0700;
    cm_q[1].push_back(8'h07);
    tick();
    recv_val = '0;
    push_en = 1'b1;
    push_msg = mk(1'b0, 1'b0, 2'd1, 8'h00);
    tick();
    push_en = 1'b0;
    pull_en = 1'b1;
    push_msg = mk(1'b0, 1'b1, 2'd1, 8'h00);
    #1;
    n_checks++;
    if (pull_msg !== pm(1'b1, 1'b1, 2'd1, cm_q[1][0]))
      $display("FAIL read_data: got %h want %h", pull_msg, pm(1'b1, 1'b1, 2'd1, cm_q[1][0]));
    else n_pass++;
    void'(cm_q[1].pop_front());
    tick();
    #1;
    n_checks++;
    if (pull_msg !== pm(1'b0, 1'b1, 2'd1, 8'h00))
      $display("FAIL read_after: got %h want %h", pull_msg, pm(1'b0, 1'b1, 2'd1, 8'h00));
    else n_pass++;
    pull_en = 1'b0;
  endtask

  task automatic test_empty_read();
    push_en = 1'b1;
    push_msg = mk(1'b0, 1'b0, 2'd3, 8'h00);
    tick();
    push_en = 1'b0;
    pull_en = 1'b1;
    push_msg = mk(1'b0, 1'b1, 2'd3, 8'h00);
    #1;
    n_checks++;
    if (pull_msg !== pm(1'b0, 1'b1, 2'd3, 8'h00))
      $display("FAIL empty_read: got %h want %h", pull_msg, pm(1'b0, 1'b1, 2'd3, 8'h00));
    else n_pass++;
    tick();
    pull_en = 1'b0;
    #1;
    n_checks++;
    if (pull_msg !== pm(1'b0, 1'b1, 2'd3, 8'h00) || recv_rdy !== 4'hF ||
        send_val !== 4'h0 || overflow !== exp_ovf)
      $display("FAIL empty_read_state: got pull=%h rdy=%h val=%h ovf=%h want 700 f 0 %h",
               pull_msg, recv_rdy, send_val, overflow, exp_ovf);
    else n_pass++;
    // A later enqueue must land as the only entry (no pointer corruption).
    recv_val[3] = 1'b1;
    recv_msg = 32'h3C00_0000;
    cm_q[3].push_back(8'h3C);
    tick();
    recv_val = '0;
    pull_en = 1'b1;
    #1;
    n_checks++;
    if (pull_msg !== pm(1'b1, 1'b1, 2'd3, cm_q[3][0]))
      $display("FAIL empty_read_recover: got %h want %h", pull_msg, pm(1'b1, 1'b1, 2'd3, cm_q[3][0]));
    else n_pass++;
    void'(cm_q[3].pop_front());
    tick();
    pull_en = 1'b0;
  endtask

  task automatic test_clear_drop();
    push_en = 1'b1;
    push_msg = mk(1'b1, 1'b1, 2'd2, 8'h99);
    exp_ovf[2] = 1'b0;
    tick();
    push_en = 1'b0;
    #1;
    n_checks++;
    if (overflow !== exp_ovf || send_val !== 4'h0)
      $display("FAIL clear: got ovf=%b val=%b want %b 0000", overflow, send_val, exp_ovf);
    else n_pass++;
    write_a(2'd2, 8'h11);
    write_a(2'd2, 8'h22);
    // Write into a full queue while it drains: still a drop.
    send_rdy[2] = 1'b1;
    push_en = 1'b1;
    push_msg = mk(1'b1, 1'b0, 2'd2, 8'h33);
    exp_ovf[2] = 1'b1;
    #1;
    n_checks++;
    if (send_msg[23:16] !== mc_q[2][0])
      $display("FAIL drop_drain_head: got %h want %h", send_msg[23:16], mc_q[2][0]);
    else n_pass++;
    void'(mc_q[2].pop_front());
    tick();
    send_rdy = '0;
    push_en = 1'b0;
    #1;
    n_checks++;
    if (overflow !== exp_ovf) $display("FAIL drop_while_deq: got %b want %b", overflow, exp_ovf);
    else n_pass++;
    write_a(2'd2, 8'h44);
    write_a(2'd2, 8'h55);
    push_en = 1'b1;
    push_msg = mk(1'b1, 1'b1, 2'd2, 8'hEE);
    exp_ovf[2] = 1'b0;
    tick();
    push_en = 1'b0;
    #1;
    n_checks++;
    if (overflow !== exp_ovf || pull_msg !== pm(1'b0, 1'b0, 2'd2, 8'h00))
      $display("FAIL clear_after_drop: got ovf=%b pull=%h want %b %h",
               overflow, pull_msg, exp_ovf, pm(1'b0, 1'b0, 2'd2, 8'h00));
    else n_pass++;
    send_rdy[2] = 1'b1;
    for (int k = 0; k < 4 && send_val[2]; k++) begin
      #1;
      n_checks++;
      if (mc_q[2].size() == 0)
        $display("FAIL clear_drain_extra: got %h want nothing", send_msg[23:16]);
      else if (send_msg[23:16] !== mc_q[2][0])
        $display("FAIL clear_drain: got %h want %h", send_msg[23:16], mc_q[2][0]);
      else n_pass++;
      if (mc_q[2].size() != 0) void'(mc_q[2].pop_front());
      tick();
    end
    send_rdy = '0;
    n_checks++;
    if (mc_q[2].size() != 0) $display("FAIL clear_drain_short: got %0d left want 0", mc_q[2].size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    write_a(2'd0, 8'hA1);
    for (int k = 2; k <= 5; k++) begin
      d = 8'hA0 + 8'(k);
      send_rdy[0] = 1'b1;
      push_en = 1'b1;
      push_msg = mk(1'b1, 1'b0, 2'd0, d);
      #1;
      n_checks++;
      if (send_msg[7:0] !== mc_q[0][0])
        $display("FAIL b2b_mc: got %h want %h", send_msg[7:0], mc_q[0][0]);
      else n_pass++;
      void'(mc_q[0].pop_front());
      mc_q[0].push_back(d);
      tick();
    end
    push_en = 1'b0;
    #1;
    n_checks++;
    if (send_msg[7:0] !== mc_q[0][0] || send_val !== 4'b0001)
      $display("FAIL b2b_mc_last: got %h val=%b want %h 0001", send_msg[7:0], send_val, mc_q[0][0]);
    else n_pass++;
    void'(mc_q[0].pop_front());
    tick();
    send_rdy = '0;

    // CM stream on ch3: recv and pull in the same cycle keep one entry queued.
    recv_val[3] = 1'b1;
    recv_msg = 32'hC100_0000;
    cm_q[3].push_back(8'hC1);
    push_en = 1'b1;
    push_msg = mk(1'b0, 1'b0, 2'd3, 8'h00);
    tick();
    push_en = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      d = 8'hC0 + 8'(k);
      recv_msg = {d, 24'h0};
      pull_en = 1'b1;
      push_msg = mk(1'b0, 1'b1, 2'd3, 8'h00);
      #1;
      n_checks++;
      if (pull_msg !== pm(1'b1, 1'b1, 2'd3, cm_q[3][0]))
        $display("FAIL b2b_cm: got %h want %h", pull_msg, pm(1'b1, 1'b1, 2'd3, cm_q[3][0]));
      else n_pass++;
      void'(cm_q[3].pop_front());
      cm_q[3].push_back(d);
      tick();
    end
    recv_val = '0;
    #1;
    n_checks++;
    if (pull_msg !== pm(1'b1, 1'b1, 2'd3, cm_q[3][0]))
      $display("FAIL b2b_cm_last: got %h want %h", pull_msg, pm(1'b1, 1'b1, 2'd3, cm_q[3][0]));
    else n_pass++;
    void'(cm_q[3].pop_front());
    tick();
    pull_en = 1'b0;
  endtask

  task automatic test_depth1();
    b_recv_val[0] = 1'b1;
    b_recv_msg = 32'h0000_005A;
    tick();
    b_recv_val = '0;
    #1;
    n_checks++;
    if (b_recv_rdy !== 4'hE || b_pull_msg !== pm(1'b1, 1'b1, 2'd0, 8'h5A))
      $display("FAIL d1_full: got rdy=%h pull=%h want e %h", b_recv_rdy, b_pull_msg,
               pm(1'b1, 1'b1, 2'd0, 8'h5A));
    else n_pass++;
    b_pull_en = 1'b1;
    b_push_msg = mk(1'b0, 1'b1, 2'd0, 8'h00);
    b_recv_val[0] = 1'b1;
    b_recv_msg = 32'h0000_006B;
    #1;
    n_checks++;
    if (b_recv_rdy !== 4'hF) $display("FAIL d1_rdy_on_deq: got %h want f", b_recv_rdy);
    else n_pass++;
    tick();
    b_pull_en = 1'b0;
    b_recv_val = '0;
    #1;
    n_checks++;
    if (b_pull_msg !== pm(1'b1, 1'b1, 2'd0, 8'h6B) || b_recv_rdy !== 4'hE)
      $display("FAIL d1_swap: got pull=%h rdy=%h want %h e", b_pull_msg, b_recv_rdy,
               pm(1'b1, 1'b1, 2'd0, 8'h6B));
    else n_pass++;
    b_push_en = 1'b1;
    b_push_msg = mk(1'b1, 1'b0, 2'd1, 8'h12);
    tick();
    b_push_msg = mk(1'b1, 1'b0, 2'd1, 8'h13);
    tick();
    b_push_en = 1'b0;
    #1;
    n_checks++;
    if (b_overflow !== 4'b0010 || b_send_msg[15:8] !== 8'h12 || b_pull_msg !== pm(1'b0, 1'b0, 2'd1, 8'h00))
      $display("FAIL d1_mc_full: got ovf=%b msg=%h pull=%h want 0010 12 %h",
               b_overflow, b_send_msg[15:8], b_pull_msg, pm(1'b0, 1'b0, 2'd1, 8'h00));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    write_a(2'd0, 8'h01);
    write_a(2'd1, 8'h02);
    write_a(2'd1, 8'h03);
    write_a(2'd1, 8'h04);
    recv_val = 4'b1100;
    recv_msg = 32'h0403_0000;
    tick();
    recv_val = '0;
    push_en = 1'b1;
    push_msg = mk(1'b0, 1'b0, 2'd3, 8'h00);
    tick();
    #1;
    n_checks++;
    if (overflow !== 4'b0010 || send_val !== 4'b0011 || pull_msg[11] !== 1'b1)
      $display("FAIL pre_reset_state: got ovf=%b val=%b pull=%h want 0010 0011 val=1",
               overflow, send_val, pull_msg);
    else n_pass++;
    // Reset with every handshake active.
    reset = 1'b1;
    push_msg = mk(1'b1, 1'b0, 2'd0, 8'h77);
    pull_en = 1'b1; send_rdy = 4'hF; recv_val = 4'hF; recv_msg = 32'h1122_3344;
    b_push_en = 1'b1; b_push_msg = mk(1'b1, 1'b0, 2'd2, 8'h66);
    b_pull_en = 1'b1; b_send_rdy = 4'hF; b_recv_val = 4'hF; b_recv_msg = 32'h5566_7788;
    tick();
    reset = 1'b0;
    idle();
    for (int c = 0; c < 4; c++) begin
      mc_q[c].delete();
      cm_q[c].delete();
    end
    exp_ovf = '0;
    #1;
    n_checks++;
    if (send_val !== 4'h0 || recv_rdy !== 4'hF || overflow !== exp_ovf ||
        pull_msg !== pm(1'b0, 1'b1, 2'd0, 8'h00) || send_msg !== 32'h0)
      $display("FAIL mid_reset: got val=%h rdy=%h ovf=%h pull=%h msg=%h want 0 f 0 400 0",
               send_val, recv_rdy, overflow, pull_msg, send_msg);
    else n_pass++;
    n_checks++;
    if (b_send_val !== 4'h0 || b_recv_rdy !== 4'hF || b_overflow !== 4'h0 ||
        b_pull_msg !== 12'h400 || b_send_msg !== 32'h0)
      $display("FAIL mid_reset_d1: got val=%h rdy=%h ovf=%h pull=%h msg=%h want 0 f 0 400 0",
               b_send_val, b_recv_rdy, b_overflow, b_pull_msg, b_send_msg);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    exp_ovf = '0;
    @(negedge clk);
    test_reset();
    test_overflow();
    test_read();
    test_empty_read();
    test_clear_drop();
    test_back_to_back();
    test_depth1();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
